spi_mem_master: RTL

//  Request-side SPI master for the spi_mem slave. Accepts one parallel read or write request,

---
 rtl/spi_mem_pkg.sv | 22 ++
 rtl/spi_shift_reg.sv | 44 ++++
 rtl/spi_mem_master.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared types and constants for the spi_mem request master
package spi_mem_pkg;

    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 8;
    localparam int WR_FRAME_LEN = 16;
    localparam int RD_FRAME_LEN = 8;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_LOW,
        ST_OP,
        ST_SHIFT,
        ST_WAIT_RDY,
        ST_RX,
        ST_WAIT_DONE
    } state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - LSB-first parallel-load/serial-out request shifter plus
// enable-gated serial-in reply shifter
module spi_shift_reg #(
    parameter int TX_W = 16,
    parameter int RX_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [TX_W-1:0] load_data_i,
    input  logic            shift_i,
    output logic            sout_o,
    input  logic            cap_en_i,
    input  logic            sin_i,
    output logic [RX_W-1:0] rx_data_o,
    output logic [RX_W-1:0] rx_next_o
);

    logic [TX_W-1:0] tx_q;
    logic [RX_W-1:0] rx_q;

    assign sout_o    = tx_q[0];
    assign rx_data_o = rx_q;
    // Bits enter at the top so the first captured bit ends up in bit 0.
    assign rx_next_o = {sin_i, rx_q[RX_W-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
            rx_q <= '0;
        end else begin
            if (load_i) begin
                tx_q <= load_data_i;
                rx_q <= '0;
            end else if (shift_i) begin
                tx_q <= {1'b0, tx_q[TX_W-1:1]};
            end
            if (cap_en_i) begin
                rx_q <= rx_next_o;
            end
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// rtl/spi_mem_master.sv - request-side SPI master: one parallel read/write request in,
// one serial frame to spi_mem, one response out
module spi_mem_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              cs,
    output logic              miso,
    input  logic              mosi,
    input  logic              ready,
    input  logic              op_done
);

    import spi_mem_pkg::*;

    localparam int FRAME_W = ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam int TCNT_W  = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              wr_q, wr_d;
    logic              cs_q, cs_d;
    logic              miso_q, miso_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              tx_load, tx_shift, tx_bit, rx_en;
    logic [DATA_W-1:0] rx_data, rx_next;
    logic [FRAME_W-1:0] tx_frame;
    logic [CNT_W-1:0]  last_bit;
    logic              timed_out;

    assign tx_frame  = {(req_wr == OP_WR) ? req_wdata : '0, req_addr};
    assign last_bit  = wr_q ? CNT_W'(FRAME_W - 1) : CNT_W'(ADDR_W - 1);
    assign timed_out = (tcnt_q == TCNT_W'(TIMEOUT - 1));

    spi_shift_reg #(
        .TX_W(FRAME_W),
        .RX_W(DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tx_load),
        .load_data_i(tx_frame),
        .shift_i    (tx_shift),
        .sout_o     (tx_bit),
        .cap_en_i   (rx_en),
        .sin_i      (mosi),
        .rx_data_o  (rx_data),
        .rx_next_o  (rx_next)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        wr_d        = wr_q;
        cs_d        = cs_q;
        miso_d      = miso_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tx_load     = 1'b0;
        tx_shift    = 1'b0;
        rx_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                miso_d = 1'b0;
                if (req_valid && req_ready_q) begin
                    wr_d    = req_wr;
                    tx_load = 1'b1;
                    cs_d    = 1'b0;
                    state_d = ST_CS_LOW;
                end
            end
            ST_CS_LOW: begin
                miso_d  = wr_q ? OP_WR : OP_RD;
                state_d = ST_OP;
            end
            ST_OP: begin
                miso_d   = tx_bit;
                tx_shift = 1'b1;
                cnt_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (cnt_q == last_bit) begin
                    // Raise cs the edge after the last bit so the slave sees a closed frame.
                    cs_d    = 1'b1;
                    miso_d  = 1'b0;
                    tcnt_d  = '0;
                    state_d = wr_q ? ST_WAIT_DONE : ST_WAIT_RDY;
                end else begin
                    miso_d   = tx_bit;
                    tx_shift = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (ready) begin
                    rx_en   = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RX;
                end else if (timed_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_RX: begin
                rx_en = 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    // A completion coinciding with the last capture answers with the full byte.
                    if (op_done) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rx_next;
                        state_d     = ST_IDLE;
                    end else begin
                        tcnt_d  = '0;
                        state_d = ST_WAIT_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (op_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? '0 : rx_data;
                    state_d     = ST_IDLE;
                end else if (timed_out) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                cs_d    = 1'b1;
                miso_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // Holding req_ready low during the response cycle keeps it disjoint from rsp_valid.
        req_ready_d = (state_d == ST_IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            wr_q        <= 1'b0;
            cs_q        <= 1'b1;
            miso_q      <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            wr_q        <= wr_d;
            cs_q        <= cs_d;
            miso_q      <= miso_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cs        = cs_q;
    assign miso      = miso_q;

endmodule
